fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready stream interface, round-to-nearest-even and full special-value handling. Exponent and mantissa widths are generic, so the same block serves binary32, binary16 and bfloat16 datapaths. It sits between an operand-issue stage and a result writeback/FIFO stage, and absorbs downstream back-pressure.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a, in_b  in  W  operands {sign, exp, frac}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  W  product
- out_flags  out  4  {invalid, overflow, underflow, inexact}; present only with FPMUL_FLAGS_EN

## Operation
- Three-stage pipeline. Stall signal adv = !out_valid | out_ready; all stages advance together when adv=1. in_ready = adv (combinational). A transfer happens on in_valid & in_ready, or on out_valid & out_ready.
- S1: unpack, classify (zero, subnormal, inf, NaN), sign = sa^sb. Biased exponent sum ea+eb−BIAS, with BIAS = 2^(EXP_W−1)−1, computed signed at EXP_W+2 bits. Mantissa product computed as {1,fa}×{1,fb}, 2·MAN_W+2 bits.
- S2: normalise. If product MSB=1, take the upper bits and add 1 to the exponent; otherwise shift by one. Extract guard and sticky (OR of all remaining bits). Round to nearest even: increment if G & (L | S). A rounding carry-out renormalises the mantissa to 1.0 and adds 1 to the exponent.
- S3: pack the result with the following priority:
  - NaN input, or inf×zero → canonical qNaN {0, all-ones, 1, 0…}; invalid=1 for inf×zero and for signalling NaN (frac MSB=0).
  - inf × finite-nonzero → signed infinity.
  - zero or subnormal input → signed zero. Subnormals are flushed to zero (FTZ/DAZ); no flags.
  - Final exponent ≥ 2^EXP_W−1 → signed infinity; overflow=1, inexact=1.
  - Final exponent ≤ 0 → signed zero; underflow=1, inexact=1.
  - Otherwise normal result; inexact = G|S.
- A bubble (in_valid=0 while adv=1) propagates as an invalid stage slot. Results are in order, with no drops and no duplicates.

## Timing
- Latency 3 cycles from the accepting edge to out_valid, given no stalls. Throughput 1 result/cycle.
- While out_valid=1 & out_ready=0, all stage registers and out_p/out_flags hold stable, and in_ready=0.
- Simultaneous output accept and input accept in the same cycle is legal; full throughput is maintained.
- Reset (asynchronous, at any time including mid-stream): all stage valids=0, out_valid=0, out_p=0, out_flags=0. In-flight operands are discarded. in_ready=1 from the first cycle after release.
- Data registers need no reset; valid bits and outputs are reset.

## Configuration
- FPMUL_FLAGS_EN defined: the out_flags port plus per-stage flag pipeline registers are present, as described above.
- Not defined: the out_flags port and its logic are absent. Product values and timing are identical.

## Test plan
- Binary32 default params. 0x3FC00000×0x40000000 (1.5×2) → 0x40400000 three cycles after accept; 0xC0000000×0x40400000 → 0xC0C00000.
- Rounding: 0x3F800001×0x3F800001 → 0x3F800002, inexact=1. Tie-to-even: 0x3F800001×0x3FC00000 → 0x3FC00002, inexact=1.
- Specials: 0x7F800000×0x00000000 → 0x7FC00000, invalid=1. 0x7F000000×0x40000000 → 0x7F800000, overflow=1. 0x00800000×0x3F000000 → 0x00000000, underflow=1. 0x80000001×0x3F800000 → 0x80000000.
- Back-pressure: stream 10 random pairs with out_ready toggling pseudo-randomly; results match a reference model in order, and out_p stays stable while stalled.
- Reset with 3 operations in flight: out_valid=0 immediately on rst_n low; after release no stale result appears; the next input's result arrives at latency 3.
- EXP_W=5, MAN_W=10: 0x3E00×0x4000 → 0x4200, and 0x7800×0x7800 → 0x7C00 with overflow=1.

Source files
------------

// File: rtl/fp_mul_pipe_if.sv
`timescale 1ns/1ps
// Valid/ready operand and result stream of fp_mul_pipe.
// The out_flags wire exists only when FPMUL_FLAGS_EN is defined.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p;

`ifdef FPMUL_FLAGS_EN
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, out_flags
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
`endif
endinterface

// File: rtl/fp_mul_pipe.sv
`timescale 1ns/1ps
// Three-stage FTZ/DAZ floating-point multiplier (round-to-nearest-even) with valid/ready flow.
// Define FPMUL_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flag pipeline.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mul_pipe_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'(2**(EXP_W-1) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'(2**EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    logic adv;

    logic [1:0][EXP_W-1:0] op_exp;
    logic [1:0][MAN_W-1:0] op_frac;
    logic [1:0]            op_sign;
    logic [1:0]            op_zero;
    logic [1:0]            op_inf;
    logic [1:0]            op_nan;
    logic                  inf_times_zero;

    logic                  s1_sign_next;
    cls_e                  s1_cls_next;
    logic signed [XW-1:0]  s1_exp_next;
    logic [PW-1:0]         s1_prod_next;

    logic                  s1_valid_reg;
    logic                  s1_sign_reg;
    cls_e                  s1_cls_reg;
    logic signed [XW-1:0]  s1_exp_reg;
    logic [PW-1:0]         s1_prod_reg;

    logic [MAN_W-1:0]      frac_sel;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [MAN_W:0]        frac_rnd;
    logic signed [XW-1:0]  exp_norm;
    logic [MAN_W-1:0]      s2_frac_next;
    logic signed [XW-1:0]  s2_exp_next;

    logic                  s2_valid_reg;
    logic                  s2_sign_reg;
    cls_e                  s2_cls_reg;
    logic [MAN_W-1:0]      s2_frac_reg;
    logic signed [XW-1:0]  s2_exp_reg;

    logic                  res_ovf;
    logic                  res_unf;
    logic [W-1:0]          out_p_next;
    logic [W-1:0]          out_p_reg;
    logic                  out_valid_reg;

`ifdef FPMUL_FLAGS_EN
    logic [1:0]            op_snan;
    logic                  s1_invalid_next;
    logic                  s1_invalid_reg;
    logic                  s2_invalid_reg;
    logic                  s2_lost_next;
    logic                  s2_lost_reg;
    logic [3:0]            out_flags_next;
    logic [3:0]            out_flags_reg;
`endif

    // Every stage moves in lock-step; the only stall source is a held result.
    assign adv          = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- Stage 1: unpack, classify, exponent sum, mantissa product
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        logic [W-1:0] opnd;
        assign opnd         = (gi == 0) ? bus.in_a : bus.in_b;
        assign op_sign[gi]  = opnd[W-1];
        assign op_exp[gi]   = opnd[W-2 -: EXP_W];
        assign op_frac[gi]  = opnd[MAN_W-1:0];
        // Exponent zero covers subnormals too: they are treated as zero.
        assign op_zero[gi]  = (op_exp[gi] == '0);
        assign op_inf[gi]   = (&op_exp[gi]) && (op_frac[gi] == '0);
        assign op_nan[gi]   = (&op_exp[gi]) && (op_frac[gi] != '0);
`ifdef FPMUL_FLAGS_EN
        assign op_snan[gi]  = op_nan[gi] && !op_frac[gi][MAN_W-1];
`endif
    end

    assign inf_times_zero = (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);

    always_comb begin
        s1_cls_next = CLS_NORMAL;
        if ((|op_nan) || inf_times_zero) begin
            s1_cls_next = CLS_NAN;
        end else if (|op_inf) begin
            s1_cls_next = CLS_INF;
        end else if (|op_zero) begin
            s1_cls_next = CLS_ZERO;
        end
    end

    assign s1_sign_next = op_sign[0] ^ op_sign[1];
    assign s1_exp_next  = $signed({2'b00, op_exp[0]}) + $signed({2'b00, op_exp[1]}) - BIAS;
    assign s1_prod_next = PW'({1'b1, op_frac[0]}) * PW'({1'b1, op_frac[1]});

`ifdef FPMUL_FLAGS_EN
    assign s1_invalid_next = inf_times_zero || (|op_snan);
`endif

    // ---------------- Stage 2: normalise and round to nearest even
    always_comb begin
        frac_sel = s1_prod_reg[PW-3 -: MAN_W];
        guard    = s1_prod_reg[MAN_W-1];
        sticky   = |s1_prod_reg[MAN_W-2:0];
        exp_norm = s1_exp_reg;
        if (s1_prod_reg[PW-1]) begin
            frac_sel = s1_prod_reg[PW-2 -: MAN_W];
            guard    = s1_prod_reg[MAN_W];
            sticky   = |s1_prod_reg[MAN_W-1:0];
            exp_norm = s1_exp_reg + XW'(1);
        end
        round_up     = guard && (frac_sel[0] || sticky);
        frac_rnd     = {1'b0, frac_sel} + {{MAN_W{1'b0}}, round_up};
        // Carry out of the fraction means the significand became 2.0: fraction wraps to 0.
        s2_frac_next = frac_rnd[MAN_W-1:0];
        s2_exp_next  = frac_rnd[MAN_W] ? exp_norm + XW'(1) : exp_norm;
    end

`ifdef FPMUL_FLAGS_EN
    assign s2_lost_next = guard || sticky;
`endif

    // ---------------- Stage 3: range check and pack
    assign res_ovf = (s2_cls_reg == CLS_NORMAL) && (s2_exp_reg >= EXP_MAX);
    assign res_unf = (s2_cls_reg == CLS_NORMAL) && !res_ovf &&
                     (s2_exp_reg[XW-1] || (s2_exp_reg == '0));

    always_comb begin
        out_p_next = {s2_sign_reg, s2_exp_reg[EXP_W-1:0], s2_frac_reg};
        case (s2_cls_reg)
            CLS_NAN:  out_p_next = QNAN;
            CLS_INF:  out_p_next = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: out_p_next = {s2_sign_reg, {(W-1){1'b0}}};
            default: begin
                if (res_ovf) begin
                    out_p_next = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (res_unf) begin
                    out_p_next = {s2_sign_reg, {(W-1){1'b0}}};
                end
            end
        endcase
    end

`ifdef FPMUL_FLAGS_EN
    always_comb begin
        out_flags_next    = 4'b0000;
        out_flags_next[3] = (s2_cls_reg == CLS_NAN) && s2_invalid_reg;
        out_flags_next[2] = res_ovf;
        out_flags_next[1] = res_unf;
        out_flags_next[0] = res_ovf || res_unf ||
                            ((s2_cls_reg == CLS_NORMAL) && s2_lost_reg);
    end
`endif

    // ---------------- Control and output registers (reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_p_reg     <= '0;
`ifdef FPMUL_FLAGS_EN
            out_flags_reg <= 4'b0000;
`endif
        end else if (adv) begin
            s1_valid_reg  <= bus.in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            // Bubbles leave the last result on out_p.
            if (s2_valid_reg) begin
                out_p_reg     <= out_p_next;
`ifdef FPMUL_FLAGS_EN
                out_flags_reg <= out_flags_next;
`endif
            end
        end
    end

    // ---------------- Datapath registers (no reset)
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign_reg <= s1_sign_next;
            s1_cls_reg  <= s1_cls_next;
            s1_exp_reg  <= s1_exp_next;
            s1_prod_reg <= s1_prod_next;
            s2_sign_reg <= s1_sign_reg;
            s2_cls_reg  <= s1_cls_reg;
            s2_exp_reg  <= s2_exp_next;
            s2_frac_reg <= s2_frac_next;
`ifdef FPMUL_FLAGS_EN
            s1_invalid_reg <= s1_invalid_next;
            s2_invalid_reg <= s1_invalid_reg;
            s2_lost_reg    <= s2_lost_next;
`endif
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_p     = out_p_reg;
`ifdef FPMUL_FLAGS_EN
    assign bus.out_flags = out_flags_reg;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_mul_pipe: binary32 and binary16 instances, directed vectors,
// back-pressure, mid-stream reset. Flag checks are active when FPMUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
    fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    typedef struct {
        logic [31:0] p;
        logic [3:0]  flags;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

    // stream vectors: {a, b, product, flags}
    logic [31:0] sv_a [10] = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h40400000, 32'hFF800000,
                               32'h7F800001, 32'h7FC00000, 32'h00000000, 32'h3F000000, 32'h40A00000};
    logic [31:0] sv_b [10] = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h40400000, 32'h40000000,
                               32'h3F800000, 32'h00000000, 32'hC0000000, 32'h3F000000, 32'h40400000};
    logic [31:0] sv_p [10] = '{32'h40800000, 32'h3F800000, 32'h3F800000, 32'h41100000, 32'hFF800000,
                               32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h3E800000, 32'h41700000};
    logic [3:0]  sv_f [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [3:0] f);
        bit   done = 1'b0;
        exp_t e;
        bus32.in_valid = 1'b1;
        bus32.in_a     = a;
        bus32.in_b     = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus32.in_ready) begin
                e.p = p;
                e.flags = f;
                q32.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus32.in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue32_timeout actual=not_accepted required=accepted a=%h b=%h", a, b);
        end else begin
            $display("issue32 a=%h b=%h expect=%h", a, b, p);
        end
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] p, input logic [3:0] f);
        bit   done = 1'b0;
        exp_t e;
        bus16.in_valid = 1'b1;
        bus16.in_a     = a;
        bus16.in_b     = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus16.in_ready) begin
                e.p = {16'h0, p};
                e.flags = f;
                q16.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus16.in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue16_timeout actual=not_accepted required=accepted a=%h b=%h", a, b);
        end else begin
            $display("issue16 a=%h b=%h expect=%h", a, b, p);
        end
    endtask

    // Called right after the accepting edge with an otherwise empty pipeline.
    task automatic lat_check32(input string name);
        @(negedge clk);
        check({name, "_c1"}, {31'h0, bus32.out_valid}, 32'h0);
        @(negedge clk);
        check({name, "_c2"}, {31'h0, bus32.out_valid}, 32'h0);
        @(negedge clk);
        check({name, "_c3"}, {31'h0, bus32.out_valid}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q32.size() == 0 && q16.size() == 0) break;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(q32.size() + q16.size()), 32'h0);
    endtask

    // out_ready driver, shared by both instances
    initial begin
        bus32.out_ready = 1'b1;
        bus16.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       begin bus32.out_ready = 1'b1; bus16.out_ready = 1'b1; end
                1:       begin bus32.out_ready = 1'b0; bus16.out_ready = 1'b0; end
                default: begin
                    bus32.out_ready = 1'($urandom_range(0, 1));
                    bus16.out_ready = bus32.out_ready;
                end
            endcase
        end
    end

    // binary32 monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus32.out_valid) begin
                if (q32.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out32 actual=%h required=no_result", bus32.out_p);
                end else if (!bus32.out_ready) begin
                    check("hold_p32", bus32.out_p, q32[0].p);
                    check("stall_in_ready32", {31'h0, bus32.in_ready}, 32'h0);
                end else begin
                    e = q32.pop_front();
                    $display("out32 p=%h expect=%h", bus32.out_p, e.p);
                    check("p32", bus32.out_p, e.p);
`ifdef FPMUL_FLAGS_EN
                    check("flags32", {28'h0, bus32.out_flags}, {28'h0, e.flags});
`endif
                end
            end
        end
    end

    // binary16 monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus16.out_valid && bus16.out_ready) begin
                if (q16.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out16 actual=%h required=no_result", bus16.out_p);
                end else begin
                    e = q16.pop_front();
                    $display("out16 p=%h expect=%h", bus16.out_p, e.p[15:0]);
                    check("p16", {16'h0, bus16.out_p}, e.p);
`ifdef FPMUL_FLAGS_EN
                    check("flags16", {28'h0, bus16.out_flags}, {28'h0, e.flags});
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid32", {31'h0, bus32.out_valid}, 32'h0);
        check("rst_out_p32", bus32.out_p, 32'h0);
        check("rst_out_valid16", {31'h0, bus16.out_valid}, 32'h0);
`ifdef FPMUL_FLAGS_EN
        check("rst_flags32", {28'h0, bus32.out_flags}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {31'h0, bus32.in_ready}, 32'h1);

        // basic products and first-result latency
        issue32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
        lat_check32("lat_basic");
        issue32(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0);
        issue32(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1);
        issue32(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1);
        issue32(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8);
        issue32(32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5);
        issue32(32'h00800000, 32'h3F000000, 32'h00000000, 4'h3);
        issue32(32'h80000001, 32'h3F800000, 32'h80000000, 4'h0);
        drain();

        // back-pressure stream
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) issue32(sv_a[i], sv_b[i], sv_p[i], sv_f[i]);
        rdy_mode = 0;
        drain();

        // reset with three operations in flight
        rdy_mode = 1;
        @(posedge clk);
        #2;
        issue32(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0);
        issue32(32'h40000000, 32'h40000000, 32'h40800000, 4'h0);
        issue32(32'h40400000, 32'h40400000, 32'h41100000, 4'h0);
        check("full_before_rst", {31'h0, bus32.out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr_valid", {31'h0, bus32.out_valid}, 32'h0);
        check("async_clr_p", bus32.out_p, 32'h0);
        q32.delete();
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst2", {31'h0, bus32.in_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", {31'h0, bus32.out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        issue32(32'h40000000, 32'h40400000, 32'h40C00000, 4'h0);
        lat_check32("lat_after_rst");
        drain();

        // binary16 instance
        issue16(16'h3E00, 16'h4000, 16'h4200, 4'h0);
        issue16(16'h7800, 16'h7800, 16'h7C00, 4'h5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
